// File: rtl/gray_readout.sv
// Column readout sequencer: enables one column at a time on the shared gray bus,
// samples it after two settled cycles and streams the decoded binary word out.
module gray_readout #(
    parameter int width   = 8,
    parameter int columns = 4,
    localparam int idx_w  = (columns > 1) ? $clog2(columns) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic [columns-1:0] col_enable,
    input  logic [width-1:0]   bus_in,
    output logic [width-1:0]   data_out,
    output logic [idx_w-1:0]   col_index,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        OUTPUT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_col;
    logic   handshake;

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [width-1:0] gray2bin(input logic [width-1:0] g);
        logic [width-1:0] b;
        b[width-1] = g[width-1];
        for (int i = width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign last_col  = (col_index == idx_w'(columns - 1));
    assign handshake = data_valid && data_ready;

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        col_enable = '0;
        case (state)
            IDLE: begin
                if (start) state_next = DRIVE;
            end
            DRIVE: begin
                col_enable = columns'(1) << col_index;
                state_next = SAMPLE;
            end
            SAMPLE: begin
                col_enable = columns'(1) << col_index;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                if (handshake) state_next = last_col ? DONE : DRIVE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            col_index  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) col_index <= '0;
                end
                SAMPLE: begin
                    // Bus has been driven by this column for two full cycles here.
                    data_out   <= gray2bin(bus_in);
                    data_valid <= 1'b1;
                end
                OUTPUT: begin
                    if (handshake) begin
                        data_valid <= 1'b0;
                        if (!last_col) col_index <= col_index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_readout.sv
// Randomized bench for gray_readout: a 4-column instance checked by a word
// scoreboard plus per-cycle bus rules, and a 1-column instance for full decode.
module tb_gray_readout;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       data_ready = 1'b1;
    logic [7:0] bus4;
    logic [3:0] col_enable4;
    logic [7:0] data_out4;
    logic [1:0] col_index4;
    logic       data_valid4, done4, busy4;

    logic       start1 = 1'b0;
    logic       ready1 = 1'b1;
    logic [7:0] bus1;
    logic [0:0] col_enable1;
    logic [7:0] data_out1;
    logic [0:0] col_index1;
    logic       data_valid1, done1, busy1;

    logic [7:0] col_gray [4];
    logic [7:0] gray1 = 8'h00;
    logic [7:0] junk = 8'h5A;
    logic [3:0] prev_en4 = 4'b0;
    logic [0:0] prev_en1 = 1'b0;

    int checks = 0;
    int failures = 0;
    int g2b [256];

    typedef struct {
        int idx;
        int data;
    } word_t;
    word_t exp_q [$];

    int   en_cnt [4];
    bit   mon_en = 1'b0;
    bit   exp_done = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [1:0] prev_idx = 2'd0;

    always #5 clk = ~clk;

    gray_readout #(.width(8), .columns(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .busy(busy4),
        .col_enable(col_enable4), .bus_in(bus4), .data_out(data_out4),
        .col_index(col_index4), .data_valid(data_valid4),
        .data_ready(data_ready), .done(done4)
    );

    gray_readout #(.width(8), .columns(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1),
        .col_enable(col_enable1), .bus_in(bus1), .data_out(data_out1),
        .col_index(col_index1), .data_valid(data_valid1),
        .data_ready(ready1), .done(done1)
    );

    // Bus model: a column's value is only settled once its enable has been
    // stable across a full cycle; otherwise the bus carries garbage.
    always @(posedge clk) begin
        junk     <= 8'($urandom);
        prev_en4 <= col_enable4;
        prev_en1 <= col_enable1;
    end

    always_comb begin
        bus4 = junk;
        for (int k = 0; k < 4; k++) begin
            if (col_enable4[k] && prev_en4 == col_enable4) bus4 = col_gray[k];
        end
    end

    always_comb begin
        bus1 = ~junk;
        if (col_enable1[0] && prev_en1[0]) bus1 = gray1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle monitor for the 4-column instance.
    always @(negedge clk) begin
        if (!mon_en) begin
            en_cnt     <= '{default: 0};
            exp_done   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            check("enable_onehot0", 32'($onehot0(col_enable4)), 1);
            if (data_valid4) check("enable_off_when_valid", col_enable4, 0);
            check("done_timing", done4, exp_done);
            if (prev_stall) begin
                check("stall_valid_held", data_valid4, 1);
                check("stall_data_held", data_out4, prev_data);
                check("stall_idx_held", col_index4, prev_idx);
            end
            for (int k = 0; k < 4; k++) en_cnt[k] <= en_cnt[k] + 32'(col_enable4[k]);
            if (data_valid4 && data_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("word_idx", col_index4, exp_q[0].idx);
                    check("word_data", data_out4, exp_q[0].data);
                    check("enable_cycles", en_cnt[exp_q[0].idx], 2);
                    en_cnt[exp_q[0].idx] <= 0;
                    exp_done <= (exp_q[0].idx == 3);
                    void'(exp_q.pop_front());
                end else begin
                    exp_done <= 1'b0;
                end
            end else begin
                exp_done <= 1'b0;
            end
            prev_stall <= data_valid4 && !data_ready;
            prev_data  <= data_out4;
            prev_idx   <= col_index4;
        end
    end

    // mode 0: ready always high; 1: random ready; 2: 5-cycle stall on column 1.
    task automatic run_frame(input int mode, input int restart_at, input string tag);
        int n = 0;
        int stalls = 0;
        int nvalid = 0;
        bit got_done = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back('{idx: k, data: g2b[col_gray[k]]});
        @(posedge clk); #1;
        start = 1'b1;
        data_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy4, 1);
        while (!got_done && n < 400) begin
            case (mode)
                1: data_ready = ($urandom_range(0, 3) != 0);
                2: data_ready = !(data_valid4 && col_index4 == 2'd1 && stalls < 5);
                default: data_ready = 1'b1;
            endcase
            start = (restart_at >= 0 && n == restart_at);
            @(negedge clk);
            n++;
            if (data_valid4) nvalid++;
            if (data_valid4 && !data_ready) begin
                stalls++;
                if (mode == 2) begin
                    check("stall_data", data_out4, 8'hFF);
                    check("stall_idx", col_index4, 1);
                end
            end
            if (done4) got_done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_frame_len"}, n, 3 * 4 + 1 + stalls);
        check({tag, "_valid_cycles"}, nvalid, 4 + stalls);
        if (mode == 2) check({tag, "_stall_count"}, stalls, 5);
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, busy4, 0);
        check({tag, "_idle_done"}, done4, 0);
        check({tag, "_all_words"}, exp_q.size(), 0);
    endtask

    task automatic reset_mid_frame();
        bit found = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back('{idx: k, data: g2b[col_gray[k]]});
        @(posedge clk); #1;
        start = 1'b1;
        data_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (col_enable4 == 4'b0010 && prev_en4 == 4'b0010) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_reached_sample1", found, 1);
        mon_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_col_enable", col_enable4, 0);
        check("rst_valid", data_valid4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_idx", col_index4, 0);
        check("rst_data", data_out4, 0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic decode_sweep();
        for (int b = 0; b < 256; b++) begin
            int n = 0;
            bit got_done = 1'b0;
            gray1 = 8'(b ^ (b >> 1));
            @(posedge clk); #1;
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            while (n < 20 && !got_done) begin
                @(negedge clk);
                n++;
                if (data_valid1) begin
                    check("dec_data", data_out1, b);
                    check("dec_idx", col_index1, 0);
                    check("dec_valid_at", n, 3);
                end
                if (done1) begin
                    got_done = 1'b1;
                    check("dec_done_at", n, 4);
                end
            end
            check("dec_done_seen", got_done, 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 256; b++) g2b[b ^ (b >> 1)] = b;
        for (int k = 0; k < 4; k++) col_gray[k] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy4, 0);
        check("reset_enable", col_enable4, 0);
        check("reset_valid", data_valid4, 0);
        check("reset_done", done4, 0);
        check("reset_data", data_out4, 0);
        check("reset_idx", col_index4, 0);
        check("reset1_valid", data_valid1, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        col_gray = '{8'h00, 8'h01, 8'h03, 8'hC0};
        run_frame(0, -1, "basic");

        col_gray = '{8'h10, 8'h80, 8'h33, 8'h5A};
        run_frame(2, -1, "stall");

        col_gray = '{8'h0F, 8'hF0, 8'hA5, 8'h3C};
        run_frame(0, 7, "restart");

        col_gray = '{8'h11, 8'h22, 8'h44, 8'h88};
        reset_mid_frame();
        run_frame(0, -1, "after_rst");

        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < 4; k++) col_gray[k] = 8'($urandom);
            run_frame(1, -1, "rand");
        end

        decode_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
